// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_I    = 2'd1,
      GNT_D    = 2'd2
   } grant_t;

   localparam int MEM_LAT_DEFAULT      = 2;
   localparam int MAX_D_STREAK_DEFAULT = 4;

   // Bits needed to hold 0..max_val; never less than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Transfer latency counter: loads 1 on start, counts up to MEM_LAT, flags terminal count.
module mem_lat_counter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   output logic o_tc
);

   localparam int CW = cnt_width(MEM_LAT);
   localparam logic [CW-1:0] LAT_V = CW'(MEM_LAT);

   logic [CW-1:0] r_cnt;

   // Zero means idle; the terminal value wraps straight back to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_cnt <= CW'(1);
      end else if (r_cnt == LAT_V) begin
         r_cnt <= '0;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_tc = (r_cnt == LAT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported fixed-latency memory between fetch and data access.
// Optional statistics counters are enabled with the ARB_STATS_EN macro.
//
// state  | meaning
// IDLE   | no transfer outstanding; grant decided and issued this cycle
// BUSY_I | fetch transfer in flight, waiting for MEM_LAT
// BUSY_D | data transfer in flight, waiting for MEM_LAT
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LAT      = MEM_LAT_DEFAULT,
   parameter int MAX_D_STREAK = MAX_D_STREAK_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_kill,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_done,
   output logic              StallMemF,
   output logic              StallMemM,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]       stat_conflicts,
   output logic [31:0]       stat_busy
`endif
);

   localparam int SW = cnt_width(MAX_D_STREAK);
   localparam logic [SW-1:0] MAX_STREAK_V = SW'(MAX_D_STREAK);

   arb_state_t    r_state, w_state_nxt;
   grant_t        w_grant;
   logic [SW-1:0] r_d_streak, w_d_streak_nxt;
   logic          r_kill_pend, w_kill_pend_nxt;
   logic          r_d_we;
   logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;
   logic          w_tc;
   logic          w_if_done, w_dm_done;
   logic          w_if_valid, w_dm_load;

   mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
      .clk     (clk),
      .rst     (rst),
      .i_start (mem_req),
      .o_tc    (w_tc)
   );

   always_comb begin
      w_grant         = GNT_NONE;
      w_state_nxt     = r_state;
      w_d_streak_nxt  = r_d_streak;
      w_kill_pend_nxt = r_kill_pend;
      w_if_done       = 1'b0;
      w_dm_done       = 1'b0;
      // Nothing is granted or completed while reset is held.
      if (!rst) begin
         case (r_state)
            IDLE: begin
               if (dm_req && (!if_req || (r_d_streak < MAX_STREAK_V))) begin
                  w_grant        = GNT_D;
                  w_state_nxt    = BUSY_D;
                  w_d_streak_nxt = if_req ? (r_d_streak + SW'(1)) : '0;
               end else if (if_req && !if_kill) begin
                  w_grant        = GNT_I;
                  w_state_nxt    = BUSY_I;
                  w_d_streak_nxt = '0;
               end
            end
            BUSY_I: begin
               if (if_kill) w_kill_pend_nxt = 1'b1;
               if (w_tc) begin
                  w_if_done       = 1'b1;
                  w_kill_pend_nxt = 1'b0;
                  w_state_nxt     = IDLE;
               end
            end
            BUSY_D: begin
               if (w_tc) begin
                  w_dm_done   = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // A squash landing on the completion cycle itself also drops the result.
   assign w_if_valid = w_if_done && !r_kill_pend && !if_kill;
   assign w_dm_load  = w_dm_done && !r_d_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_d_streak  <= '0;
         r_kill_pend <= 1'b0;
         r_d_we      <= 1'b0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_d_streak  <= w_d_streak_nxt;
         r_kill_pend <= w_kill_pend_nxt;
         if (w_grant == GNT_D) r_d_we <= dm_we;
         if (w_if_valid) r_if_rdata <= mem_rdata;
         if (w_dm_load)  r_dm_rdata <= mem_rdata;
      end
   end

   assign mem_req   = (w_grant != GNT_NONE);
   assign mem_we    = (w_grant == GNT_D) && dm_we;
   assign mem_addr  = (w_grant == GNT_D) ? dm_addr :
                      (w_grant == GNT_I) ? if_addr : '0;
   assign mem_wdata = (w_grant == GNT_D) ? dm_wdata : '0;

   // Results are forwarded straight from memory on the completion cycle, then held.
   assign if_valid  = w_if_valid;
   assign if_rdata  = w_if_valid ? mem_rdata : r_if_rdata;
   assign dm_done   = w_dm_done;
   assign dm_rdata  = w_dm_load ? mem_rdata : r_dm_rdata;

   assign StallMemF = if_req && !w_if_valid;
   assign StallMemM = dm_req && !w_dm_done;

`ifdef ARB_STATS_EN
   logic [31:0] r_stat_conflicts, r_stat_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_conflicts <= '0;
         r_stat_busy      <= '0;
      end else begin
         if ((r_state == IDLE) && if_req && dm_req && (r_stat_conflicts != '1))
            r_stat_conflicts <= r_stat_conflicts + 32'd1;
         if ((r_state != IDLE) && (r_stat_busy != '1))
            r_stat_busy <= r_stat_busy + 32'd1;
      end
   end

   assign stat_conflicts = r_stat_conflicts;
   assign stat_busy      = r_stat_busy;
`endif

endmodule
